ll_window_acc: RTL and testbench

- Multi-channel, windowed line-length feature engine for the seizure-detection datapath.
- Accepts time-multiplexed integer samples in round-robin channel order and computes per-channel abs(x[i] - x[i-1]).
- Accumulates WIN consecutive differences per channel and emits one line-length value per channel per window, with a threshold flag.
- Sits between the sample front-end and the feature memory/classifier; generalises the single-channel, per-sample abs-difference unit.

---
 rtl/ll_pkg.sv | 27 ++
 rtl/ll_absdiff.sv | 37 +++
 rtl/ll_window_acc.sv | 147 ++++++++++++++
 tb/tb_ll_window_acc.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ll_pkg.sv
// Shared widths and types for the windowed line-length engine.
// Derived widths are functions so each module can size itself from its own parameters.
package ll_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_WIN    = 256;

  function automatic int ch_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  // One extra bit for the signed difference, plus log2(WIN) bits of accumulation growth.
  function automatic int out_w(input int data_w, input int win);
    return data_w + 1 + $clog2(win);
  endfunction

  function automatic int diff_w(input int data_w);
    return data_w + 1;
  endfunction

  localparam int DIFF_W = diff_w(DEF_DATA_W);

  typedef logic signed [DEF_DATA_W-1:0]             sample_t;
  typedef logic        [DIFF_W-1:0]                 abs_t;
  typedef logic        [out_w(DEF_DATA_W, DEF_WIN)-1:0] acc_t;

endpackage

// File: rtl/ll_absdiff.sv
// Stage 1 datapath: registered |din - prev| in DATA_W+1 bits.
// The register only loads on a primed, accepted sample.
module ll_absdiff
  import ll_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                        clk,
  input  logic                        ld,
  input  logic signed [DATA_W-1:0]    din,
  input  logic signed [DATA_W-1:0]    prev,
  output logic [diff_w(DATA_W)-1:0]   abs_p1
);

  localparam int DW = diff_w(DATA_W);

  logic [DW-1:0] abs_p1_d, abs_p1_q;

  function automatic logic [DW-1:0] abs_diff(input logic signed [DATA_W-1:0] a,
                                             input logic signed [DATA_W-1:0] b);
    logic signed [DW-1:0] d;
    d = $signed({a[DATA_W-1], a}) - $signed({b[DATA_W-1], b});
    return d[DW-1] ? $unsigned(-d) : $unsigned(d);
  endfunction

  always_comb begin
    abs_p1_d = abs_p1_q;
    if (ld) abs_p1_d = abs_diff(din, prev);
  end

  always_ff @(posedge clk) begin
    abs_p1_q <= abs_p1_d;
  end

  assign abs_p1 = abs_p1_q;

endmodule

// File: rtl/ll_window_acc.sv
// Multi-channel windowed line-length engine: per-channel |x[i]-x[i-1]| summed over
// WIN differences, one thresholded result per channel per window, 2 cycles after the closing sample.
module ll_window_acc
  import ll_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_CH   = 4,
  parameter int WIN    = DEF_WIN,
  parameter int CH_W   = ch_w(N_CH),
  parameter int OUT_W  = out_w(DATA_W, WIN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] din,
  input  logic                     en,
  input  logic [OUT_W-1:0]         thresh,
  output logic [OUT_W-1:0]         ll_out,
  output logic [CH_W-1:0]          ll_ch,
  output logic                     ll_valid,
  output logic                     ll_over
);

  localparam int DW   = diff_w(DATA_W);
  localparam int WC_W = $clog2(WIN);

  logic                     accept, wrap;
  logic [CH_W-1:0]          ch_cnt_d, ch_cnt_q;
  logic [WC_W-1:0]          win_cnt_d, win_cnt_q;
  logic                     primed_d, primed_q;
  logic signed [DATA_W-1:0] prev_d [N_CH];
  logic signed [DATA_W-1:0] prev_q [N_CH];
  logic [OUT_W-1:0]         acc_d [N_CH];
  logic [OUT_W-1:0]         acc_q [N_CH];
  logic [OUT_W-1:0]         acc_sum;

  logic                     vld_p1_d, vld_p1_q;
  logic [CH_W-1:0]          ch_p1_d, ch_p1_q;
  logic                     first_p1_d, first_p1_q;
  logic                     last_p1_d, last_p1_q;
  logic [DW-1:0]            abs_p1;

  logic                     vld_p2_d, vld_p2_q;
  logic [CH_W-1:0]          ch_p2_d, ch_p2_q;
  logic [OUT_W-1:0]         sum_p2_d, sum_p2_q;
  logic [OUT_W-1:0]         thresh_p2_d, thresh_p2_q;

  logic [OUT_W-1:0]         ll_out_d, ll_out_q;
  logic [CH_W-1:0]          ll_ch_d, ll_ch_q;
  logic                     ll_valid_d, ll_valid_q;
  logic                     ll_over_d, ll_over_q;

  ll_absdiff #(.DATA_W(DATA_W)) u_absdiff (
    .clk    (clk),
    .ld     (vld_p1_d),
    .din    (din),
    .prev   (prev_q[ch_cnt_q]),
    .abs_p1 (abs_p1)
  );

  always_comb begin
    accept    = ~en;
    wrap      = (ch_cnt_q == CH_W'(N_CH - 1));
    ch_cnt_d  = ch_cnt_q;
    win_cnt_d = win_cnt_q;
    primed_d  = primed_q;
    prev_d    = prev_q;
    acc_d     = acc_q;

    // Stage 0 -> 1: counters, prev capture, stage-1 control
    vld_p1_d   = accept & primed_q;
    ch_p1_d    = ch_cnt_q;
    first_p1_d = (win_cnt_q == '0);
    last_p1_d  = (win_cnt_q == WC_W'(WIN - 1));
    if (accept) begin
      prev_d[ch_cnt_q] = din;
      ch_cnt_d         = wrap ? '0 : ch_cnt_q + 1'b1;
      if (wrap) begin
        primed_d = 1'b1;
        if (primed_q) win_cnt_d = last_p1_d ? '0 : win_cnt_q + 1'b1;
      end
    end

    // Stage 1 -> 2: accumulate; the first difference of a window restarts the sum
    acc_sum = first_p1_q ? OUT_W'(abs_p1) : acc_q[ch_p1_q] + OUT_W'(abs_p1);
    if (vld_p1_q) acc_d[ch_p1_q] = acc_sum;
    vld_p2_d    = vld_p1_q & last_p1_q;
    ch_p2_d     = ch_p1_q;
    sum_p2_d    = acc_sum;
    thresh_p2_d = thresh;

    // Stage 2 -> output: held between pulses
    ll_valid_d = vld_p2_q;
    ll_out_d   = ll_out_q;
    ll_ch_d    = ll_ch_q;
    ll_over_d  = ll_over_q;
    if (vld_p2_q) begin
      ll_out_d  = sum_p2_q;
      ll_ch_d   = ch_p2_q;
      ll_over_d = (sum_p2_q > thresh_p2_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_cnt_q   <= '0;
      win_cnt_q  <= '0;
      primed_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      ll_out_q   <= '0;
      ll_ch_q    <= '0;
      ll_valid_q <= 1'b0;
      ll_over_q  <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        prev_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      ch_cnt_q   <= ch_cnt_d;
      win_cnt_q  <= win_cnt_d;
      primed_q   <= primed_d;
      vld_p1_q   <= vld_p1_d;
      vld_p2_q   <= vld_p2_d;
      ll_out_q   <= ll_out_d;
      ll_ch_q    <= ll_ch_d;
      ll_valid_q <= ll_valid_d;
      ll_over_q  <= ll_over_d;
      prev_q     <= prev_d;
      acc_q      <= acc_d;
    end
  end

  always_ff @(posedge clk) begin
    ch_p1_q     <= ch_p1_d;
    first_p1_q  <= first_p1_d;
    last_p1_q   <= last_p1_d;
    ch_p2_q     <= ch_p2_d;
    sum_p2_q    <= sum_p2_d;
    thresh_p2_q <= thresh_p2_d;
  end

  assign ll_out   = ll_out_q;
  assign ll_ch    = ll_ch_q;
  assign ll_valid = ll_valid_q;
  assign ll_over  = ll_over_q;

endmodule

// File: tb/tb_ll_window_acc.sv
// Scoreboard bench for ll_window_acc: a 1-channel and a 2-channel instance (DATA_W=8, WIN=4)
// driven from tasks; expected windows are queued at drive time and popped on each ll_valid pulse.
module tb_ll_window_acc;

  localparam int DATA_W = 8;
  localparam int WIN    = 4;
  localparam int OUT_W  = DATA_W + 1 + $clog2(WIN);

  typedef struct {
    int out;
    int ch;
    bit over;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  logic signed [DATA_W-1:0] din1 = '0, din2 = '0;
  logic                     en1 = 1'b1, en2 = 1'b1;
  logic [OUT_W-1:0]         thr1 = 11'd1000, thr2 = 11'd1000;
  logic [OUT_W-1:0]         o1, o2;
  logic                     c1, c2;
  logic                     v1, v2;
  logic                     ov1, ov2;

  int total = 0;
  int bad   = 0;

  exp_t q1[$];
  exp_t q2[$];

  int mprev [2][2];
  int macc  [2][2];
  bit mprimed [2];
  int mch [2];
  int mwin [2];

  ll_window_acc #(.DATA_W(DATA_W), .N_CH(1), .WIN(WIN)) dut1 (
    .clk(clk), .rst(rst), .din(din1), .en(en1), .thresh(thr1),
    .ll_out(o1), .ll_ch(c1), .ll_valid(v1), .ll_over(ov1)
  );

  ll_window_acc #(.DATA_W(DATA_W), .N_CH(2), .WIN(WIN)) dut2 (
    .clk(clk), .rst(rst), .din(din2), .en(en2), .thresh(thr2),
    .ll_out(o2), .ll_ch(c2), .ll_valid(v2), .ll_over(ov2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      mprimed[d] = 1'b0;
      mch[d]     = 0;
      mwin[d]    = 0;
      for (int c = 0; c < 2; c++) begin
        mprev[d][c] = 0;
        macc[d][c]  = 0;
      end
    end
    q1.delete();
    q2.delete();
  endtask

  // Behavioural model of one accepted sample on DUT d, accepted at edge t
  task automatic model(input int d, input int x, input int t);
    int   c, nch, dd, th;
    exp_t e;
    c   = mch[d];
    nch = d + 1;
    th  = (d == 0) ? int'(thr1) : int'(thr2);
    if (mprimed[d]) begin
      dd = x - mprev[d][c];
      if (dd < 0) dd = -dd;
      macc[d][c] = (mwin[d] == 0) ? dd : macc[d][c] + dd;
      if (mwin[d] == WIN - 1) begin
        e.out  = macc[d][c];
        e.ch   = c;
        e.over = (macc[d][c] > th);
        e.cyc  = t + 2;
        if (d == 0) q1.push_back(e);
        else        q2.push_back(e);
      end
    end
    mprev[d][c] = x;
    if (c == nch - 1) begin
      mch[d] = 0;
      if (mprimed[d]) mwin[d] = (mwin[d] + 1) % WIN;
      mprimed[d] = 1'b1;
    end else begin
      mch[d] = c + 1;
    end
  endtask

  task automatic send(input int d, input int x);
    @(negedge clk);
    en1 = 1'b1;
    en2 = 1'b1;
    if (d == 0) begin din1 = DATA_W'(x); en1 = 1'b0; end
    else        begin din2 = DATA_W'(x); en2 = 1'b0; end
    model(d, x, cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en1 = 1'b1;
      en2 = 1'b1;
    end
  endtask

  // Reset with a sample strobed in the same cycle; that sample must be discarded
  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    en1  = 1'b0; din1 = 8'sd100;
    en2  = 1'b0; din2 = 8'sd100;
    @(negedge clk);
    rst = 1'b0;
    en1 = 1'b1;
    en2 = 1'b1;
    model_clear();
  endtask

  task automatic drain(input string tag);
    idle(6);
    chk({tag, "_q1_empty"}, q1.size(), 0);
    chk({tag, "_q2_empty"}, q2.size(), 0);
  endtask

  task automatic base_seq(input int gap);
    int s[5] = '{0, 3, -2, 5, 5};
    for (int i = 0; i < 5; i++) begin
      send(0, s[i]);
      if (gap > 0 && i < 4) idle(gap);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (v1 === 1'b1) begin
      if (q1.size() == 0) chk("spurious1", 1, 0);
      else begin
        e = q1.pop_front();
        chk("out1", o1, e.out);
        chk("ch1", c1, e.ch);
        chk("over1", ov1, e.over);
        chk("lat1", cyc, e.cyc);
      end
    end
    if (v2 === 1'b1) begin
      if (q2.size() == 0) chk("spurious2", 1, 0);
      else begin
        e = q2.pop_front();
        chk("out2", o2, e.out);
        chk("ch2", c2, e.ch);
        chk("over2", ov2, e.over);
        chk("lat2", cyc, e.cyc);
      end
    end
  end

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_out1", o1, 0);
    chk("rst_ch1", c1, 0);
    chk("rst_vld1", v1, 0);
    chk("rst_over1", ov1, 0);
    chk("rst_out2", o2, 0);
    chk("rst_ch2", c2, 0);
    chk("rst_vld2", v2, 0);
    chk("rst_over2", ov2, 0);
    rst = 1'b0;

    // Basic window: diffs 3,5,7,0
    base_seq(0);
    drain("t1");
    chk("hold_out1", o1, 15);
    chk("hold_ch1", c1, 0);

    // Full-scale swing, two windows with prev carried across
    do_reset();
    for (int i = 0; i < 9; i++) send(0, (i % 2 == 0) ? -128 : 127);
    drain("t2");
    chk("hold_max1", o1, 1020);

    // Two interleaved channels
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(1, i);
      send(1, (i % 2 == 0) ? 10 : 0);
    end
    drain("t3");
    chk("hold_out2", o2, 40);
    chk("hold_ch2", c2, 1);

    // Stalls between every sample
    do_reset();
    base_seq(3);
    drain("t4");
    chk("stall_out1", o1, 15);

    // Abort a window with reset mid-stream, then rerun
    do_reset();
    send(0, 0);
    send(0, 3);
    send(0, -2);
    do_reset();
    chk("abort_vld1", v1, 0);
    chk("abort_out1", o1, 0);
    base_seq(0);
    drain("t5");

    // Threshold is strict greater-than
    do_reset();
    thr1 = 11'd15;
    base_seq(0);
    drain("t6a");
    chk("thr15_over1", ov1, 0);
    do_reset();
    thr1 = 11'd14;
    base_seq(0);
    drain("t6b");
    chk("thr14_over1", ov1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1);
  end

endmodule
